// File: rtl/random_pkg.sv
// Shared types and constants for the random_range draw unit.
package random_pkg;

  // Width of the generator word consumed per draw.
  localparam int RND_W      = 32;
  // One remainder step per dividend bit.
  localparam int DIV_CYCLES = 32;
  // Bit-index width inside the serial remainder unit.
  localparam int BIT_W      = $clog2(DIV_CYCLES);
  // Sample-delay counter width; SAMPLE_DLY is limited to 1..15.
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DIV,
    DONE
  } state_e;

endpackage

// File: rtl/random_range_serial_mod.sv
// Serial restoring remainder: dividend mod divisor, MSB first, one bit per
// clock, DIV_CYCLES clocks after load.
module serial_mod
  import random_pkg::*;
#(
  parameter int LIM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [RND_W-1:0] dividend,
  input  logic [LIM_W-1:0] divisor,
  output logic [LIM_W-1:0] rem,
  output logic             rem_valid
);

  logic [RND_W-1:0] div_q, div_d;
  logic [LIM_W-1:0] rem_q, rem_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             act_q, act_d;

  // Shifted-in partial remainder is one bit wider than the divisor so that
  // a divisor of 2^LIM_W-1 can never overflow it.
  logic [LIM_W:0] rem_t;
  logic [LIM_W:0] rem_step;

  // One restoring step on the current partial remainder.
  always_comb begin
    rem_t    = {rem_q, div_q[bit_q]};
    rem_step = (rem_t >= {1'b0, divisor}) ? (rem_t - {1'b0, divisor}) : rem_t;
  end

  // The step result is always below the divisor, so its top bit is zero.
  assign rem       = rem_step[LIM_W-1:0];
  assign rem_valid = act_q && (bit_q == '0);

  // Next-state: load a new dividend or advance one bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    div_d = div_q;
    rem_d = rem_q;
    bit_d = bit_q;
    act_d = act_q;
    if (load) begin
      div_d = dividend;
      rem_d = '0;
      bit_d = BIT_W'(DIV_CYCLES - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      rem_d = rem_step[LIM_W-1:0];
      bit_d = bit_q - 1'b1;
      if (bit_q == '0) act_d = 1'b0;
    end
  end

  // Control state is reset; the dividend only matters after a load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples values from before this edge.
    if (!reset) begin
      rem_q <= '0;
      bit_q <= '0;
      act_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      bit_q <= bit_d;
      act_q <= act_d;
    end
  end

  // NOTE: the dividend register carries no reset; it is only read while
  // act_q is set, and act_q can only rise through a load that writes it.
  always_ff @(posedge clk) begin
    div_q <= div_d;
  end

endmodule

// File: rtl/random_range.sv
// Draws one word from the LCG generator and reduces it to 0..limit-1
// (optionally offset by one) with a serial remainder unit.
module random_range
  import random_pkg::*;
#(
  parameter int LIM_W      = 8,
  parameter int SAMPLE_DLY = 2,
  parameter int ONE_BASED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LIM_W-1:0] limit,
  input  logic [RND_W-1:0] rnd_in,
  output logic             rnd_req,
  output logic             busy,
  output logic             done,
  output logic [LIM_W-1:0] result,
  output logic             err
);

  localparam logic [LIM_W-1:0] OFFSET = (ONE_BASED != 0) ? LIM_W'(1) : '0;

  state_e           state_q, state_d;
  logic [LIM_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rnd_req_q, rnd_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LIM_W-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             load;
  logic [LIM_W-1:0] rem;
  logic             rem_valid;

  // Capture the generator word on the last wait cycle.
  assign load = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  serial_mod #(
    .LIM_W(LIM_W)
  ) u_mod (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dividend (rnd_in),
    .divisor  (lim_q),
    .rem      (rem),
    .rem_valid(rem_valid)
  );

  // Draw sequencing; every output is computed one cycle ahead and registered.
  always_comb begin
    state_d   = state_q;
    lim_d     = lim_q;
    cnt_d     = cnt_q;
    rnd_req_d = 1'b0;
    done_d    = 1'b0;
    result_d  = result_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lim_d = limit;
          if (limit == '0) begin
            // No modulus: report the error without touching the generator.
            state_d  = DONE;
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            state_d   = REQ;
            rnd_req_d = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_d   = CNT_W'(SAMPLE_DLY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DIV;
      end
      DIV: begin
        if (rem_valid) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = rem + OFFSET;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      lim_q     <= '0;
      cnt_q     <= '0;
      rnd_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      cnt_q     <= cnt_d;
      rnd_req_q <= rnd_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  assign rnd_req = rnd_req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign err     = err_q;

endmodule

// File: tb/tb_random_range.sv
// Directed bench for random_range: one-based and zero-based instances share
// stimulus; a small LCG stub stands in for the generator.
module tb_random_range;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  limit = 8'd0;
  logic [31:0] rnd_in;
  logic [31:0] rnd_man = 32'd0;
  logic        use_gen = 1'b0;
  logic        gen_load = 1'b0;
  logic [31:0] gen_q = 32'd0;

  logic        rnd_req, busy, done, err;
  logic [7:0]  result;
  logic        rnd_req0, busy0, done0, err0;
  logic [7:0]  result0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rnd_in = use_gen ? gen_q : rnd_man;

  // Generator stand-in: x' = 22695477*x + 1 on each request.
  always @(posedge clk) begin
    if (gen_load) gen_q <= 32'd13;
    else if (use_gen && rnd_req) gen_q <= gen_q * 32'd22695477 + 32'd1;
  end

  random_range #(.LIM_W(8), .SAMPLE_DLY(2), .ONE_BASED(1)) dut (
    .clk(clk), .reset(reset), .start(start), .limit(limit), .rnd_in(rnd_in),
    .rnd_req(rnd_req), .busy(busy), .done(done), .result(result), .err(err)
  );

  random_range #(.LIM_W(8), .SAMPLE_DLY(2), .ONE_BASED(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .limit(limit), .rnd_in(rnd_in),
    .rnd_req(rnd_req0), .busy(busy0), .done(done0), .result(result0), .err(err0)
  );

  // One draw; cycle 1 is the cycle after start is sampled. kind 1 scrambles
  // rnd_in at hook_cyc, kind 2 pulses start and changes limit at hook_cyc.
  task automatic run_draw(input logic [7:0] lim, input int kind, input int hook_cyc,
                          output int done_cyc, output int req_cnt, output int busy_cnt);
    done_cyc = -1;
    req_cnt  = 0;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    limit = lim;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == hook_cyc && kind == 1) rnd_man = 32'h0;
      if (cyc == hook_cyc && kind == 2) begin
        start = 1'b1;
        limit = 8'd7;
      end
      if (cyc == hook_cyc + 1 && kind == 2) start = 1'b0;
      req_cnt  += int'(rnd_req);
      busy_cnt += int'(busy);
      if (done) done_cyc = cyc;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (rnd_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", rnd_req); end
    tests++; if (result !== 8'd0)  begin fails++; $display("FAIL reset_result: got %0d want 0", result); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b1;
  endtask

  // 22695490 mod 6 = 4, so a one-based die shows 5; rnd_in is zeroed mid-DIV.
  task automatic test_basic;
    int dc, rc, bc;
    rnd_man = 32'd22695490;
    run_draw(8'd6, 1, 20, dc, rc, bc);
    tests++; if (dc !== 36)        begin fails++; $display("FAIL basic_latency: got %0d want 36", dc); end
    tests++; if (rc !== 1)         begin fails++; $display("FAIL basic_req_cycles: got %0d want 1", rc); end
    tests++; if (bc !== 36)        begin fails++; $display("FAIL basic_busy_cycles: got %0d want 36", bc); end
    tests++; if (result !== 8'd5)  begin fails++; $display("FAIL basic_result: got %0d want 5", result); end
    tests++; if (result0 !== 8'd4) begin fails++; $display("FAIL basic_result0: got %0d want 4", result0); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL basic_err: got %b want 0", err); end
  endtask

  task automatic test_limit_zero;
    int dc, rc, bc;
    rnd_man = 32'd12345;
    run_draw(8'd0, 0, -5, dc, rc, bc);
    tests++; if (dc !== 1)        begin fails++; $display("FAIL zero_latency: got %0d want 1", dc); end
    tests++; if (err !== 1'b1)    begin fails++; $display("FAIL zero_err: got %b want 1", err); end
    tests++; if (result !== 8'd0) begin fails++; $display("FAIL zero_result: got %0d want 0", result); end
    tests++; if (rc !== 0)        begin fails++; $display("FAIL zero_req: got %0d want 0", rc); end
    tests++; if (bc !== 1)        begin fails++; $display("FAIL zero_busy_cycles: got %0d want 1", bc); end
    @(negedge clk);
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL zero_busy_after: got %b want 0", busy); end
    tests++; if (err !== 1'b1)    begin fails++; $display("FAIL zero_err_hold: got %b want 1", err); end
  endtask

  // 2^32-1 is a multiple of 255; also exercises the widest remainder path.
  task automatic test_max;
    int dc, rc, bc;
    rnd_man = 32'hFFFF_FFFF;
    run_draw(8'd255, 0, -5, dc, rc, bc);
    tests++; if (dc !== 36)        begin fails++; $display("FAIL max_latency: got %0d want 36", dc); end
    tests++; if (result !== 8'd1)  begin fails++; $display("FAIL max_result: got %0d want 1", result); end
    tests++; if (result0 !== 8'd0) begin fails++; $display("FAIL max_result0: got %0d want 0", result0); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL max_err: got %b want 0", err); end
    // 0xFFFFFFFE mod 255 = 254, the largest remainder.
    rnd_man = 32'hFFFF_FFFE;
    run_draw(8'd255, 0, -5, dc, rc, bc);
    tests++; if (result !== 8'd255)  begin fails++; $display("FAIL max254_result: got %0d want 255", result); end
    tests++; if (result0 !== 8'd254) begin fails++; $display("FAIL max254_result0: got %0d want 254", result0); end
  endtask

  task automatic test_limit_one;
    int dc, rc, bc;
    rnd_man = 32'hDEAD_BEEF;
    run_draw(8'd1, 0, -5, dc, rc, bc);
    tests++; if (result !== 8'd1)  begin fails++; $display("FAIL one_result: got %0d want 1", result); end
    tests++; if (result0 !== 8'd0) begin fails++; $display("FAIL one_result0: got %0d want 0", result0); end
  endtask

  // Start pulse and limit=7 during DIV must not affect the draw (mod 7 gives 7).
  task automatic test_ignore_mid_draw;
    int dc, rc, bc, extra;
    rnd_man = 32'd22695490;
    run_draw(8'd6, 2, 10, dc, rc, bc);
    tests++; if (dc !== 36)       begin fails++; $display("FAIL ignore_latency: got %0d want 36", dc); end
    tests++; if (result !== 8'd5) begin fails++; $display("FAIL ignore_result: got %0d want 5", result); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      extra += int'(done);
    end
    tests++; if (extra !== 0)     begin fails++; $display("FAIL ignore_queued: got %0d extra done want 0", extra); end
  endtask

  // start held high against the LCG stub seeded with 13.
  task automatic test_back_to_back;
    logic [31:0] w;
    logic [7:0]  exp_r;
    int seen, last;
    use_gen = 1'b1;
    @(negedge clk);
    gen_load = 1'b1;
    @(negedge clk);
    gen_load = 1'b0;
    w     = 32'd13;
    start = 1'b1;
    limit = 8'd6;
    seen  = 0;
    last  = 0;
    for (int cyc = 1; cyc <= 200 && seen < 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        w     = w * 32'd22695477 + 32'd1;
        exp_r = 8'(w % 32'd6 + 32'd1);
        if (seen == 0) begin
          tests++; if (w !== 32'd295041202) begin fails++; $display("FAIL b2b_word: model %0d want 295041202", w); end
          tests++; if (cyc !== 36) begin fails++; $display("FAIL b2b_first_latency: got %0d want 36", cyc); end
        end else begin
          tests++; if (cyc - last !== 37) begin fails++; $display("FAIL b2b_period: got %0d want 37", cyc - last); end
        end
        tests++; if (result !== exp_r) begin fails++; $display("FAIL b2b_result%0d: got %0d want %0d", seen, result, exp_r); end
        tests++; if (result < 8'd1 || result > 8'd6) begin fails++; $display("FAIL b2b_range%0d: got %0d want 1..6", seen, result); end
        last = cyc;
        seen++;
        if (seen == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    tests++; if (seen !== 3) begin fails++; $display("FAIL b2b_timeout: got %0d draws want 3", seen); end
    use_gen = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Reset in DIV cycle 20 (cycle 23 of the draw) clears everything.
  task automatic test_reset_mid_div;
    int dc, rc, bc;
    rnd_man = 32'd22695490;
    @(negedge clk);
    start = 1'b1;
    limit = 8'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rst_div_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL rst_div_done: got %b want 0", done); end
    tests++; if (rnd_req !== 1'b0) begin fails++; $display("FAIL rst_div_req: got %b want 0", rnd_req); end
    tests++; if (result !== 8'd0)  begin fails++; $display("FAIL rst_div_result: got %0d want 0", result); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL rst_div_err: got %b want 0", err); end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_div_resumed: busy %b done %b want 0 0", busy, done); end
    run_draw(8'd6, 0, -5, dc, rc, bc);
    tests++; if (dc !== 36)       begin fails++; $display("FAIL rst_div_redraw_latency: got %0d want 36", dc); end
    tests++; if (result !== 8'd5) begin fails++; $display("FAIL rst_div_redraw_result: got %0d want 5", result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit_zero();
    test_max();
    test_limit_one();
    test_ignore_mid_draw();
    test_back_to_back();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/random_range.md
Name: random_range

Overview:
- Downstream consumer of the 32-bit LCG random generator. On a start pulse it requests one word, captures it, and reduces it serially to the range 0..limit-1.
- It returns the result with an optional +1 offset, so a 6-sided die yields 1..6.
- Sits between the generator and game/display logic; drives the generator's request input and reads its out bus.

Parameters:
- LIM_W, 8, width of limit and result.
- SAMPLE_DLY, 2, clock cycles waited after the request pulse before rnd_in is captured (range 1..15).
- ONE_BASED, 1, when 1 result = remainder+1; when 0 result = remainder.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin one draw; sampled only in IDLE.
- limit  input  LIM_W  modulus; latched when start is accepted.
- rnd_in  input  32  random word from generator out.
- rnd_req  output  1  request to generator; registered, glitch-free.
- busy  output  1  high from the cycle after start acceptance through DONE.
- done  output  1  one-cycle pulse; result/err valid this cycle.
- result  output  LIM_W  reduced random value; holds until next done.
- err  output  1  set with done when latched limit was 0; holds until next done.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; rnd_req, busy, done, err = 0; result = 0. This overrides any state, including mid-DIV. No draw is resumed.
- States: IDLE, REQ, WAIT, DIV, DONE.
- IDLE: if start, latch limit into lim_q.
  - lim_q==0: go to DONE with err_next=1, result_next=0; rnd_req is never asserted.
  - Otherwise go to REQ.
  - start in any other state is ignored, and is not queued.
- REQ: rnd_req=1 for exactly one cycle; load wait counter with SAMPLE_DLY; go to WAIT.
- WAIT: rnd_req=0; decrement counter. In the final WAIT cycle, capture rnd_in into a 32-bit dividend at that edge, clear rem, set bit_cnt=31, and go to DIV.
- DIV: restoring remainder, MSB first, one bit per cycle, 32 cycles.
  - rem_t = {rem, dividend[bit_cnt]}, width LIM_W+1.
  - rem = (rem_t >= lim_q) ? rem_t - lim_q : rem_t.
  - After the bit_cnt==0 step, go to DONE.
- DONE: done=1; result = rem + ONE_BASED, truncated to LIM_W bits.
  - err=0 for a normal draw, 1 for the limit==0 path.
  - Next state is IDLE.
- Latency: start sampled at end of cycle 0 gives REQ in cycle 1, WAIT in cycles 2..1+SAMPLE_DLY, DIV in 32 cycles, done in cycle 34+SAMPLE_DLY (36 at default).
  - limit==0 path: done in cycle 1.
- Back-to-back: start held high retriggers from IDLE one cycle after DONE, giving period 35+SAMPLE_DLY cycles. Request spacing always far exceeds the generator's 3-cycle recompute.
- Boundaries:
  - limit=1 gives remainder 0.
  - limit = 2^LIM_W-1 with rnd_in = 0xFFFFFFFF must not overflow rem (LIM_W+1 bits internally).
  - ONE_BASED with remainder = 2^LIM_W-1 cannot occur, because remainder ≤ limit-1.
- rnd_in is ignored outside the capture edge.

Decomposition:
- Package random_pkg:
  - state enum (IDLE, REQ, WAIT, DIV, DONE).
  - RND_W=32.
  - DIV_CYCLES=32.
- Sub-module serial_mod: serial restoring remainder unit.
  - Ports: clk, reset, load, dividend[31:0], divisor[LIM_W-1:0], rem, rem_valid.
  - random_range owns the FSM, request handshake and output registers.

Test Plan:
- Behavioural generator stub drives rnd_in=22695490 at rnd_req rise; limit=6, ONE_BASED=1.
  - Expect rnd_req high exactly 1 cycle, done in cycle 36, result=5, err=0.
- limit=0, start pulse.
  - Expect done in cycle 1, err=1, result=0, rnd_req never asserted, busy high only in the DONE cycle.
- rnd_in=0xFFFFFFFF, limit=255.
  - Expect remainder 0, result=1; with ONE_BASED=0 result=0.
- Integration with real generator (seed 13), limit=6, first draw.
  - Captured word 295041202, result=5.
  - start held high: successive done pulses every 37 cycles, each result in 1..6.
- start pulsed during DIV, and limit changed mid-draw.
  - Both ignored; result uses the originally latched limit.
- reset driven low during cycle 20 of DIV.
  - Next edge: busy=0, done=0, rnd_req=0, result=0, err=0.
  - Subsequent start completes normally.
